// File: rtl/sram_wishbone_port_if.sv
// Wishbone classic bus bundle between the data-bus interconnect and the SRAM port block.
interface sram_wishbone_port_if #(
  parameter int BYTE_COUNT       = 4,
  parameter int BUS_ADDRESS_SIZE = 24
);
  localparam int WORD_SIZE = 8 * BYTE_COUNT;

  logic                        wb_cyc_i;
  logic                        wb_stb_i;
  logic                        wb_we_i;
  logic [BYTE_COUNT-1:0]       wb_sel_i;
  logic [BUS_ADDRESS_SIZE-1:0] wb_adr_i;
  logic [WORD_SIZE-1:0]        wb_data_i;
  logic                        wb_ack_o;
  logic                        wb_error_o;
  logic                        wb_stall_o;
  logic [WORD_SIZE-1:0]        wb_data_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_data_i,
    output wb_ack_o, wb_error_o, wb_stall_o, wb_data_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_data_i,
    input  wb_ack_o, wb_error_o, wb_stall_o, wb_data_o
  );
endinterface

// File: rtl/sram_wishbone_port.sv
// Wishbone classic slave driving the primary read/write port of the SRAM wrapper.
// One registered SRAM access per request; every output comes straight from a flop.
//
// state   | meaning
// IDLE    | waiting for cyc & stb
// ACCESS  | SRAM select asserted for this cycle
// CAPTURE | SRAM read data valid, captured at the end of this cycle
// ACK     | wb_ack_o high
// ERROR   | wb_error_o high (address out of range)
module sram_wishbone_port #(
  parameter int BYTE_COUNT       = 4,
  parameter int ADDRESS_SIZE     = 9,
  parameter int BUS_ADDRESS_SIZE = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  sram_wishbone_port_if.slave       bus,
  output logic                      primarySelect,
  output logic                      primaryWriteEnable,
  output logic [BYTE_COUNT-1:0]     primaryWriteMask,
  output logic [ADDRESS_SIZE-1:0]   primaryAddress,
  output logic [8*BYTE_COUNT-1:0]   primaryDataIn,
  input  logic [8*BYTE_COUNT-1:0]   primaryDataRead
);
  localparam int WORD_SIZE = 8 * BYTE_COUNT;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCESS  = 3'd1,
    CAPTURE = 3'd2,
    ACK     = 3'd3,
    ERROR   = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic                    latch_req, capture;
  logic                    ack_q, error_q, stall_q, select_q, we_q;
  logic [BYTE_COUNT-1:0]   mask_q;
  logic [ADDRESS_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0]    din_q, rdata_q;

  logic request, out_of_range;
  assign request      = bus.wb_cyc_i & bus.wb_stb_i;
  assign out_of_range = |bus.wb_adr_i[BUS_ADDRESS_SIZE-1:ADDRESS_SIZE+2];

  // Byte offset within a word is meaningless to a word-wide SRAM.
  logic unused_adr_bits;
  assign unused_adr_bits = ^bus.wb_adr_i[1:0];

  always_comb begin
    state_d   = state_q;
    latch_req = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (request) begin
          if (out_of_range) begin
            state_d = ERROR;
          end else begin
            state_d   = ACCESS;
            latch_req = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (!bus.wb_cyc_i)  state_d = IDLE;
        else if (we_q)      state_d = ACK;
        else                state_d = CAPTURE;
      end
      CAPTURE: begin
        if (!bus.wb_cyc_i) begin
          state_d = IDLE;
        end else begin
          capture = 1'b1;
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each pulse lines up with its state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      error_q  <= 1'b0;
      stall_q  <= 1'b0;
      select_q <= 1'b0;
      we_q     <= 1'b0;
      mask_q   <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= (state_d == ACK);
      error_q  <= (state_d == ERROR);
      stall_q  <= (state_d != IDLE);
      select_q <= (state_d == ACCESS);
      if (latch_req) begin
        addr_q <= bus.wb_adr_i[ADDRESS_SIZE+1:2];
        we_q   <= bus.wb_we_i;
        mask_q <= bus.wb_we_i ? bus.wb_sel_i : {BYTE_COUNT{1'b1}};
        din_q  <= bus.wb_data_i;
      end
      if (capture) rdata_q <= primaryDataRead;
    end
  end

  assign bus.wb_ack_o       = ack_q;
  assign bus.wb_error_o     = error_q;
  assign bus.wb_stall_o     = stall_q;
  assign bus.wb_data_o      = rdata_q;
  assign primarySelect      = select_q;
  assign primaryWriteEnable = we_q;
  assign primaryWriteMask   = mask_q;
  assign primaryAddress     = addr_q;
  assign primaryDataIn      = din_q;
endmodule
